// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register: holds the decoded control bundle and operands,
// with stall, flush bubbles, a sticky halt after an end instruction and a bubble counter.
module id_ex_reg #(
    parameter int XLEN  = 32,
    parameter int RIDX  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallE,
    input  logic             flushE,
    input  logic             mem_to_regD,
    input  logic             mem_writeD,
    input  logic [2:0]       mem_sizeD,
    input  logic [1:0]       alu_srcAD,
    input  logic [1:0]       alu_srcBD,
    input  logic             reg_writeD,
    input  logic             jumpD,
    input  logic [3:0]       alu_controlD,
    input  logic             jump_srcD,
    input  logic             endD,
    input  logic             branchD,
    input  logic             inv_branchD,
    input  logic [XLEN-1:0]  rd1D,
    input  logic [XLEN-1:0]  rd2D,
    input  logic [XLEN-1:0]  immD,
    input  logic [XLEN-1:0]  pcD,
    input  logic [RIDX-1:0]  rs1D,
    input  logic [RIDX-1:0]  rs2D,
    input  logic [RIDX-1:0]  rdD,
    output logic             mem_to_regE,
    output logic             mem_writeE,
    output logic [2:0]       mem_sizeE,
    output logic [1:0]       alu_srcAE,
    output logic [1:0]       alu_srcBE,
    output logic             reg_writeE,
    output logic             jumpE,
    output logic [3:0]       alu_controlE,
    output logic             jump_srcE,
    output logic             endE,
    output logic             branchE,
    output logic             inv_branchE,
    output logic [XLEN-1:0]  rd1E,
    output logic [XLEN-1:0]  rd2E,
    output logic [XLEN-1:0]  immE,
    output logic [XLEN-1:0]  pcE,
    output logic [RIDX-1:0]  rs1E,
    output logic [RIDX-1:0]  rs2E,
    output logic [RIDX-1:0]  rdE,
    output logic             validE,
    output logic             haltedE,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic            mem_to_reg;
        logic            mem_write;
        logic [2:0]      mem_size;
        logic [1:0]      alu_srcA;
        logic [1:0]      alu_srcB;
        logic            reg_write;
        logic            jump;
        logic [3:0]      alu_control;
        logic            jump_src;
        logic            fin;
        logic            branch;
        logic            inv_branch;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [RIDX-1:0] rs1;
        logic [RIDX-1:0] rs2;
        logic [RIDX-1:0] rd;
    } bundle_t;

    bundle_t          in_b;
    bundle_t          bundle_d, bundle_q;
    logic             valid_d, valid_q;
    logic             halted_d, halted_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        in_b.mem_to_reg  = mem_to_regD;
        in_b.mem_write   = mem_writeD;
        in_b.mem_size    = mem_sizeD;
        in_b.alu_srcA    = alu_srcAD;
        in_b.alu_srcB    = alu_srcBD;
        in_b.reg_write   = reg_writeD;
        in_b.jump        = jumpD;
        in_b.alu_control = alu_controlD;
        in_b.jump_src    = jump_srcD;
        in_b.fin         = endD;
        in_b.branch      = branchD;
        in_b.inv_branch  = inv_branchD;
        in_b.rd1         = rd1D;
        in_b.rd2         = rd2D;
        in_b.imm         = immD;
        in_b.pc          = pcD;
        in_b.rs1         = rs1D;
        in_b.rs2         = rs2D;
        in_b.rd          = rdD;
    end

    always_comb begin
        bundle_d = bundle_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        if (flushE) begin
            // Bubble clears rd too, so forwarding logic never matches it.
            bundle_d = '0;
            valid_d  = 1'b0;
            cnt_d    = sat_inc(cnt_q);
        end else if (!stallE) begin
            bundle_d = in_b;
            valid_d  = !halted_q;
            if (halted_q) begin
                // Past an end instruction nothing may cause architectural side effects.
                bundle_d.fin       = 1'b0;
                bundle_d.reg_write = 1'b0;
                bundle_d.mem_write = 1'b0;
                bundle_d.jump      = 1'b0;
                bundle_d.branch    = 1'b0;
            end else if (endD) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bundle_q <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            bundle_q <= bundle_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mem_to_regE  = bundle_q.mem_to_reg;
    assign mem_writeE   = bundle_q.mem_write;
    assign mem_sizeE    = bundle_q.mem_size;
    assign alu_srcAE    = bundle_q.alu_srcA;
    assign alu_srcBE    = bundle_q.alu_srcB;
    assign reg_writeE   = bundle_q.reg_write;
    assign jumpE        = bundle_q.jump;
    assign alu_controlE = bundle_q.alu_control;
    assign jump_srcE    = bundle_q.jump_src;
    assign endE         = bundle_q.fin;
    assign branchE      = bundle_q.branch;
    assign inv_branchE  = bundle_q.inv_branch;
    assign rd1E         = bundle_q.rd1;
    assign rd2E         = bundle_q.rd2;
    assign immE         = bundle_q.imm;
    assign pcE          = bundle_q.pc;
    assign rs1E         = bundle_q.rs1;
    assign rs2E         = bundle_q.rs2;
    assign rdE          = bundle_q.rd;
    assign validE       = valid_q;
    assign haltedE      = halted_q;
    assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized self-checking bench for id_ex_reg: a default-width instance and a 2-bit
// counter instance share stimulus and are compared against a behavioural model.
module tb_id_ex_reg;

    typedef struct packed {
        logic        mem_to_reg;
        logic        mem_write;
        logic [2:0]  mem_size;
        logic [1:0]  alu_srcA;
        logic [1:0]  alu_srcB;
        logic        reg_write;
        logic        jump;
        logic [3:0]  alu_control;
        logic        jump_src;
        logic        fin;
        logic        branch;
        logic        inv_branch;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } bun_t;

    logic clk = 1'b0;
    logic reset, stallE, flushE;
    bun_t dIn;

    always #5 clk = ~clk;

    // Main instance outputs
    logic        mem_to_regE, mem_writeE, reg_writeE, jumpE, jump_srcE, endE, branchE, inv_branchE;
    logic [2:0]  mem_sizeE;
    logic [1:0]  alu_srcAE, alu_srcBE;
    logic [3:0]  alu_controlE;
    logic [31:0] rd1E, rd2E, immE, pcE;
    logic [4:0]  rs1E, rs2E, rdE;
    logic        validE, haltedE;
    logic [31:0] bubble_cnt;

    // Saturation instance outputs
    logic        s_mem_to_regE, s_mem_writeE, s_reg_writeE, s_jumpE, s_jump_srcE, s_endE, s_branchE, s_inv_branchE;
    logic [2:0]  s_mem_sizeE;
    logic [1:0]  s_alu_srcAE, s_alu_srcBE;
    logic [3:0]  s_alu_controlE;
    logic [31:0] s_rd1E, s_rd2E, s_immE, s_pcE;
    logic [4:0]  s_rs1E, s_rs2E, s_rdE;
    logic        s_validE, s_haltedE;
    logic [1:0]  s_bubble_cnt;

    id_ex_reg u_dut (
        .clk(clk), .reset(reset), .stallE(stallE), .flushE(flushE),
        .mem_to_regD(dIn.mem_to_reg), .mem_writeD(dIn.mem_write), .mem_sizeD(dIn.mem_size),
        .alu_srcAD(dIn.alu_srcA), .alu_srcBD(dIn.alu_srcB), .reg_writeD(dIn.reg_write),
        .jumpD(dIn.jump), .alu_controlD(dIn.alu_control), .jump_srcD(dIn.jump_src),
        .endD(dIn.fin), .branchD(dIn.branch), .inv_branchD(dIn.inv_branch),
        .rd1D(dIn.rd1), .rd2D(dIn.rd2), .immD(dIn.imm), .pcD(dIn.pc),
        .rs1D(dIn.rs1), .rs2D(dIn.rs2), .rdD(dIn.rd),
        .mem_to_regE(mem_to_regE), .mem_writeE(mem_writeE), .mem_sizeE(mem_sizeE),
        .alu_srcAE(alu_srcAE), .alu_srcBE(alu_srcBE), .reg_writeE(reg_writeE),
        .jumpE(jumpE), .alu_controlE(alu_controlE), .jump_srcE(jump_srcE),
        .endE(endE), .branchE(branchE), .inv_branchE(inv_branchE),
        .rd1E(rd1E), .rd2E(rd2E), .immE(immE), .pcE(pcE),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .validE(validE), .haltedE(haltedE), .bubble_cnt(bubble_cnt)
    );

    id_ex_reg #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .stallE(stallE), .flushE(flushE),
        .mem_to_regD(dIn.mem_to_reg), .mem_writeD(dIn.mem_write), .mem_sizeD(dIn.mem_size),
        .alu_srcAD(dIn.alu_srcA), .alu_srcBD(dIn.alu_srcB), .reg_writeD(dIn.reg_write),
        .jumpD(dIn.jump), .alu_controlD(dIn.alu_control), .jump_srcD(dIn.jump_src),
        .endD(dIn.fin), .branchD(dIn.branch), .inv_branchD(dIn.inv_branch),
        .rd1D(dIn.rd1), .rd2D(dIn.rd2), .immD(dIn.imm), .pcD(dIn.pc),
        .rs1D(dIn.rs1), .rs2D(dIn.rs2), .rdD(dIn.rd),
        .mem_to_regE(s_mem_to_regE), .mem_writeE(s_mem_writeE), .mem_sizeE(s_mem_sizeE),
        .alu_srcAE(s_alu_srcAE), .alu_srcBE(s_alu_srcBE), .reg_writeE(s_reg_writeE),
        .jumpE(s_jumpE), .alu_controlE(s_alu_controlE), .jump_srcE(s_jump_srcE),
        .endE(s_endE), .branchE(s_branchE), .inv_branchE(s_inv_branchE),
        .rd1E(s_rd1E), .rd2E(s_rd2E), .immE(s_immE), .pcE(s_pcE),
        .rs1E(s_rs1E), .rs2E(s_rs2E), .rdE(s_rdE),
        .validE(s_validE), .haltedE(s_haltedE), .bubble_cnt(s_bubble_cnt)
    );

    bun_t obs_a, obs_s;
    assign obs_a = {mem_to_regE, mem_writeE, mem_sizeE, alu_srcAE, alu_srcBE, reg_writeE, jumpE,
                    alu_controlE, jump_srcE, endE, branchE, inv_branchE,
                    rd1E, rd2E, immE, pcE, rs1E, rs2E, rdE};
    assign obs_s = {s_mem_to_regE, s_mem_writeE, s_mem_sizeE, s_alu_srcAE, s_alu_srcBE, s_reg_writeE,
                    s_jumpE, s_alu_controlE, s_jump_srcE, s_endE, s_branchE, s_inv_branchE,
                    s_rd1E, s_rd2E, s_immE, s_pcE, s_rs1E, s_rs2E, s_rdE};

    // Behavioural reference state
    bun_t   m_b      = '0;
    bit     m_valid  = 1'b0;
    bit     m_halted = 1'b0;
    longint m_cnt    = 0;
    longint m_cnt2   = 0;
    localparam longint CMAX  = 64'h0000_0000_FFFF_FFFF;
    localparam longint CMAX2 = 3;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bun_t rand_bun();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return bun_t'(r[$bits(bun_t)-1:0]);
    endfunction

    task automatic model_update();
        if (reset) begin
            m_b = '0; m_valid = 0; m_halted = 0; m_cnt = 0; m_cnt2 = 0;
        end else if (flushE) begin
            m_b = '0;
            m_valid = 0;
            if (m_cnt < CMAX) m_cnt++;
            if (m_cnt2 < CMAX2) m_cnt2++;
        end else if (!stallE) begin
            m_b = dIn;
            m_valid = !m_halted;
            if (m_halted) begin
                m_b.fin = 0; m_b.reg_write = 0; m_b.mem_write = 0; m_b.jump = 0; m_b.branch = 0;
            end else if (dIn.fin) begin
                m_halted = 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "/bundle"}, obs_a, m_b);
        check({tag, "/valid"},  validE, m_valid);
        check({tag, "/halted"}, haltedE, m_halted);
        check({tag, "/cnt"},    bubble_cnt, m_cnt);
        check({tag, "/s_bundle"}, obs_s, m_b);
        check({tag, "/s_valid"},  s_validE, m_valid);
        check({tag, "/s_halted"}, s_haltedE, m_halted);
        check({tag, "/s_cnt"},    s_bubble_cnt, m_cnt2);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all(tag);
    endtask

    bun_t snap;

    initial begin
        reset = 1'b1; stallE = 1'b0; flushE = 1'b0; dIn = rand_bun();
        step("reset1");
        dIn = rand_bun();
        step("reset2");
        check("rst_valid", validE, 0);
        check("rst_halted", haltedE, 0);
        check("rst_cnt", bubble_cnt, 0);
        check("rst_bundle", obs_a, 0);

        reset = 1'b0;
        dIn = rand_bun();
        dIn.alu_control = 4'h0; dIn.reg_write = 1; dIn.rd = 5; dIn.rd1 = 7; dIn.rd2 = 9; dIn.fin = 0;
        step("add");
        check("add_regw", reg_writeE, 1);
        check("add_rd", rdE, 5);
        check("add_rd1", rd1E, 7);
        check("add_rd2", rd2E, 9);
        check("add_valid", validE, 1);

        snap = obs_a;
        stallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dIn = rand_bun(); dIn.fin = 0;
            step("stall");
            check("stall_hold", obs_a, snap);
            check("stall_cnt", bubble_cnt, 0);
        end

        flushE = 1'b1;
        dIn = rand_bun(); dIn.branch = 1; dIn.fin = 0;
        step("flush_stall");
        check("fs_branch", branchE, 0);
        check("fs_valid", validE, 0);
        check("fs_rd", rdE, 0);
        check("fs_cnt", bubble_cnt, 1);
        flushE = 1'b0; stallE = 1'b0;

        dIn = rand_bun(); dIn.fin = 1;
        step("end_load");
        check("end_halted", haltedE, 1);
        check("end_endE", endE, 1);
        check("end_valid", validE, 1);
        dIn = rand_bun(); dIn.fin = 0; dIn.mem_write = 1;
        step("sw_after_end");
        check("sw_memw", mem_writeE, 0);
        check("sw_valid", validE, 0);
        check("sw_halted", haltedE, 1);
        for (int i = 0; i < 6; i++) begin
            dIn = rand_bun();
            flushE = (i == 2); stallE = (i == 4);
            step("post_halt");
            check("halt_sticky", haltedE, 1);
        end
        flushE = 1'b0; stallE = 1'b0;

        reset = 1'b1; step("reset3"); reset = 1'b0;
        flushE = 1'b1; dIn = rand_bun(); dIn.fin = 1;
        step("flush_end");
        check("flush_end_halted", haltedE, 0);
        check("flush_end_endE", endE, 0);
        flushE = 1'b0;

        reset = 1'b1; step("reset4"); reset = 1'b0;
        flushE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dIn = rand_bun();
            step("sat_flush");
        end
        check("sat_cnt2", s_bubble_cnt, 3);
        check("sat_cnt32", bubble_cnt, 5);

        stallE = 1'b1; reset = 1'b1; dIn = rand_bun();
        step("reset_mid");
        check("reset_mid_cnt", bubble_cnt, 0);
        check("reset_mid_scnt", s_bubble_cnt, 0);
        reset = 1'b0; flushE = 1'b0; stallE = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            dIn = rand_bun();
            dIn.fin = ($urandom_range(0, 19) == 0);
            reset  = ($urandom_range(0, 59) == 0);
            flushE = ($urandom_range(0, 6) == 0);
            stallE = ($urandom_range(0, 4) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
